fpa_arbiter: RTL and testbench
==============================

# fpa_arbiter

Round-robin scheduler that shares one registered FP32 adder (`fpa_with_regisers`) among `NUM_REQ` requesters. Accepts at most one operation per cycle via valid/ready, registers the operands into the adder and tracks each in-flight operation by requester ID. Routes each `sum` and `overflow` back to the issuing requester after a fixed latency. Supports a flush/drain sequence for mode changes.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `FPA_LAT`, 2: adder latency in cycles, from operands valid at adder input to `fpa_sum` valid.
- `ID_W`, `$clog2(NUM_REQ)`: requester ID width (derived, not overridable).
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester operation valid.
- `req_ready`  out  NUM_REQ  per-requester grant; a handshake is `req_valid[i] & req_ready[i]`.
- `req_a`  in  NUM_REQ*32  operand A; requester i at bits [32i+31:32i].
- `req_b`  in  NUM_REQ*32  operand B, same packing.
- `req_op`  in  NUM_REQ  0 = add, 1 = subtract (see Configuration).
- `rsp_valid`  out  NUM_REQ  one-hot result strobe, one cycle.
- `rsp_sum`  out  32  result, valid with `rsp_valid`.
- `rsp_overflow`  out  1  adder overflow, valid with `rsp_valid`.
- `flush`  in  1  level request: stop granting and drain.
- `flush_done`  out  1  high while in DONE state.
- `fpa_en`  out  1  adder register enable.
- `fpa_a`, `fpa_b`  out  32  registered operands to the adder.
- `fpa_sum`  in  32; `fpa_overflow`  in  1  adder outputs.

## Operation
- States: RUN, DRAIN, DONE.
  - RUN -> DRAIN when `flush` = 1.
  - DRAIN -> DONE when the tag pipeline is empty.
  - DONE -> RUN when `flush` = 0.
- Grant is issued only in RUN with `flush` = 0.
- `req_ready` is combinational and one-hot: it marks the first requester with `req_valid` = 1, searching from `rr_ptr` upward and wrapping modulo NUM_REQ. `req_ready` is all zeros outside RUN.
- `req_ready` does not depend on adder occupancy. The adder accepts one operation per cycle, so a full pipeline never back-pressures.
- On a handshake by requester g:
  - `fpa_a` and `fpa_b` load that requester's operands at the clock edge.
  - `rr_ptr` loads (g+1) mod NUM_REQ.
  - Tag {valid = 1, id = g} enters stage 0 of the tag shift register.
- With no handshake, `rr_ptr`, `fpa_a` and `fpa_b` hold, and stage 0 loads valid = 0.
- The tag shift register has depth FPA_LAT+1 and advances every cycle. At the last stage, a valid tag drives `rsp_valid[id]` = 1, with `rsp_sum` = `fpa_sum` and `rsp_overflow` = `fpa_overflow`.
- `rsp_valid` is combinational from the last tag stage. `rsp_sum` and `rsp_overflow` pass through directly from the adder.
- Responses have no back-pressure; requesters must accept them.
- `fpa_en` = 1 when any tag stage is valid or a handshake occurs this cycle, else 0. The adder holds its state while idle.
- Operand values are not interpreted: NaN, infinity and zero pass through unchanged.

## Timing
- Reset values:
  - state = RUN, `rr_ptr` = 0, all tags invalid.
  - `fpa_a` = `fpa_b` = 0, `fpa_en` = 0.
  - `req_ready` = 0 while reset is asserted.
  - `rsp_valid` = 0, `rsp_sum` / `rsp_overflow` follow the adder, `flush_done` = 0.
- Latency: a handshake in cycle t produces `rsp_valid` in cycle t+1+FPA_LAT. Issue throughput is one operation per cycle.
- `flush` asserted in the same cycle as a candidate handshake: no grant; the requester keeps waiting.
- DRAIN takes at most FPA_LAT+1 cycles. `flush_done` rises the cycle after the last response.
- If `flush` is released during DRAIN, the block still reaches DONE, then returns to RUN on the next cycle.
- Reset asserted mid-operation discards all in-flight tags; no response is produced for them.
- `rr_ptr` wraps NUM_REQ-1 -> 0.

## Configuration
- `FPA_ARB_SUB_EN` defined: when `req_op` = 1, the arbiter loads `fpa_b` = {~b[31], b[30:0]}, i.e. A − B.
- `FPA_ARB_SUB_EN` undefined: `req_op` is ignored and every operation is an add.

## Structure
- Package `fpa_pkg` holds:
  - `FP_W` = 32, the `fp32_t` typedef, and the sign-bit index constant.
  - `fpa_arb_state_t` enum {RUN, DRAIN, DONE}.
- Sub-module `rr_arbiter` contains the one-hot round-robin grant logic: inputs `req`, `ptr`; output `gnt`.
- The adder is instantiated outside this block and connected through the `fpa_*` ports.

## Test plan
- Single op: requester 0 sends a = 0x42019999 (32.4), b = 0x4124CCCC (10.3) -> `rsp_valid` = 0001 exactly FPA_LAT+1 cycles later, `rsp_sum` = 0x422ACCCC, `rsp_overflow` = 0.
- Fairness: all four requesters hold `req_valid` for 8 cycles -> grants are 0, 1, 2, 3, 0, 1, 2, 3 on consecutive cycles, and responses come back in the same ID order.
- Subtract (with `FPA_ARB_SUB_EN`): requester 2 sends 32.4 and 10.3 with `req_op` = 1 -> `fpa_b` = 0xC124CCCC on the cycle after the grant. Without the macro -> `fpa_b` = 0x4124CCCC.
- Flush: issue on 3 back-to-back cycles, then assert `flush` -> `req_ready` = 0 immediately, 3 responses arrive, `flush_done` = 1 the cycle after the last one. Deassert `flush` -> grants resume.
- Reset mid-flight: drop `reset` to 0 one cycle after a grant -> no `rsp_valid` ever appears for that op, `rr_ptr` = 0 and all outputs return to their reset values.
- Pass-through: a = 0x7F800000 (+inf), b = 0xC1B428F5 on requester 3 -> the response returns on ID 3 with `rsp_sum` equal to whatever the adder produces.

Source files
------------

// File: rtl/fpa_pkg.sv
// rtl/fpa_pkg.sv - shared FP32 types, constants and state encoding for the adder arbiter
package fpa_pkg;

    localparam int FP_W        = 32;
    localparam int FP_SIGN_BIT = FP_W - 1;

    typedef logic [FP_W-1:0] fp32_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } fpa_arb_state_t;

    // Flipping only the sign bit turns A + B into A - B without touching NaN payloads.
    function automatic fp32_t fp_negate(input fp32_t x);
        fp32_t r;
        r              = x;
        r[FP_SIGN_BIT] = ~x[FP_SIGN_BIT];
        return r;
    endfunction

endpackage

// File: rtl/fpa_arbiter_if.sv
// rtl/fpa_arbiter_if.sv - requester-side operation and response bundle for fpa_arbiter
interface fpa_arbiter_if
    import fpa_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*FP_W-1:0] req_a;
    logic [NUM_REQ*FP_W-1:0] req_b;
    logic [NUM_REQ-1:0]      req_op;
    logic [NUM_REQ-1:0]      rsp_valid;
    fp32_t                   rsp_sum;
    logic                    rsp_overflow;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output req_op,
        input  req_ready,
        input  rsp_valid,
        input  rsp_sum,
        input  rsp_overflow
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  req_op,
        output req_ready,
        output rsp_valid,
        output rsp_sum,
        output rsp_overflow
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - one-hot round-robin grant: first request at or above ptr, wrapping
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [$clog2(N)-1:0]  ptr,
    output logic [N-1:0]          gnt
);

    localparam int ID_W = $clog2(N);

    logic [ID_W:0]   pos;
    logic [ID_W-1:0] idx;
    logic            found;

    // pos = (ptr + k) mod N; ptr < N and k < N so one conditional subtract suffices.
    always_comb begin
        gnt   = '0;
        pos   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (ID_W+1)'(k);
            if (pos >= (ID_W+1)'(N)) begin
                pos = pos - (ID_W+1)'(N);
            end
            idx = pos[ID_W-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpa_arbiter.sv
// rtl/fpa_arbiter.sv - round-robin sharing of one registered FP32 adder; FPA_ARB_SUB_EN enables subtract
module fpa_arbiter
    import fpa_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int FPA_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    fpa_arbiter_if.slave req_if,
    input  logic         flush,
    output logic         flush_done,
    output logic         fpa_en,
    output fp32_t        fpa_a,
    output fp32_t        fpa_b,
    input  fp32_t        fpa_sum,
    input  logic         fpa_overflow
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TAG_D = FPA_LAT + 1;

    fpa_arb_state_t     state_q;
    fpa_arb_state_t     state_d;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [TAG_D-1:0]   tag_vld_q;
    logic [ID_W-1:0]    tag_id_q [TAG_D];

    logic               grant_en;
    logic               drain_last;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] ready;
    logic [NUM_REQ-1:0] rsp_vld;
    logic               hs;
    logic [ID_W-1:0]    gnt_id;
    logic               op_sel;
    fp32_t              a_sel;
    fp32_t              b_raw;
    fp32_t              b_sel;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr (
        .req(req_if.req_valid),
        .ptr(rr_ptr_q),
        .gnt(gnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave DRAIN while the final tag sits in the last stage, so flush_done
    // rises the cycle right after the last response.
    assign drain_last = ~|tag_vld_q[TAG_D-2:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (flush)      state_d = DRAIN;
            DRAIN:   if (drain_last) state_d = DONE;
            DONE:    if (!flush)     state_d = RUN;
            default:                 state_d = RUN;
        endcase
    end

    always_comb begin
        grant_en   = 1'b0;
        flush_done = 1'b0;
        unique case (state_q)
            RUN:     grant_en   = reset && !flush;
            DONE:    flush_done = 1'b1;
            default: grant_en   = 1'b0;
        endcase
    end

    assign ready            = grant_en ? gnt : '0;
    assign hs               = |(req_if.req_valid & ready);
    assign req_if.req_ready = ready;

    always_comb begin
        gnt_id = '0;
        a_sel  = '0;
        b_raw  = '0;
        op_sel = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_id = ID_W'(i);
                a_sel  = req_if.req_a[i*FP_W +: FP_W];
                b_raw  = req_if.req_b[i*FP_W +: FP_W];
                op_sel = req_if.req_op[i];
            end
        end
    end

`ifdef FPA_ARB_SUB_EN
    assign b_sel = op_sel ? fp_negate(b_raw) : b_raw;
`else
    logic unused_op;
    assign unused_op = op_sel;
    assign b_sel     = b_raw;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q  <= '0;
            fpa_a     <= '0;
            fpa_b     <= '0;
            tag_vld_q <= '0;
            for (int s = 0; s < TAG_D; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            tag_vld_q   <= {tag_vld_q[TAG_D-2:0], hs};
            tag_id_q[0] <= gnt_id;
            for (int s = 1; s < TAG_D; s++) begin
                tag_id_q[s] <= tag_id_q[s-1];
            end
            if (hs) begin
                rr_ptr_q <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
                fpa_a    <= a_sel;
                fpa_b    <= b_sel;
            end
        end
    end

    // The adder only needs clocking while something is in flight or entering.
    assign fpa_en = hs | (|tag_vld_q);

    always_comb begin
        rsp_vld = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_vld[i] = tag_vld_q[TAG_D-1] && (tag_id_q[TAG_D-1] == ID_W'(i));
        end
    end

    assign req_if.rsp_valid    = rsp_vld;
    assign req_if.rsp_sum      = fpa_sum;
    assign req_if.rsp_overflow = fpa_overflow;

endmodule

// File: tb/tb_fpa_arbiter.sv
// tb/tb_fpa_arbiter.sv - directed vector bench for fpa_arbiter with a behavioural two-stage adder
module tb_fpa_arbiter;
    import fpa_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int FPA_LAT = 2;
    localparam int NVEC    = 33;

    logic  clk = 1'b0;
    logic  reset;
    logic  flush;
    logic  flush_done;
    logic  fpa_en;
    logic  fpa_overflow;
    fp32_t fpa_a;
    fp32_t fpa_b;
    fp32_t fpa_sum;

    fpa_arbiter_if #(.NUM_REQ(NUM_REQ)) rif ();

    fpa_arbiter #(
        .NUM_REQ(NUM_REQ),
        .FPA_LAT(FPA_LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_if(rif),
        .flush(flush),
        .flush_done(flush_done),
        .fpa_en(fpa_en),
        .fpa_a(fpa_a),
        .fpa_b(fpa_b),
        .fpa_sum(fpa_sum),
        .fpa_overflow(fpa_overflow)
    );

    always #5 clk = ~clk;

    // Stand-in adder: one known real sum, otherwise a distinctive integer add.
    function automatic logic [32:0] add_model(input fp32_t a, input fp32_t b);
        logic  ov;
        fp32_t s;
        ov = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
        if (a == 32'h42019999 && b == 32'h4124CCCC) s = 32'h422ACCCC;
        else                                        s = a + b;
        return {ov, s};
    endfunction

    logic [32:0] st1 = '0;
    logic [32:0] st2 = '0;
    always @(posedge clk) begin
        if (fpa_en) begin
            st1 <= add_model(fpa_a, fpa_b);
            st2 <= st1;
        end
    end
    assign fpa_sum      = st2[31:0];
    assign fpa_overflow = st2[32];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] valid;
        logic       flush;
        logic [3:0] ready;
        logic [3:0] rsp;
        fp32_t      sum;
        logic       done;
    } vec_t;

    vec_t  vecs [NVEC];
    fp32_t a_op [4];
    fp32_t b_op [4];

    task automatic drive_ops();
        rif.req_a = {a_op[3], a_op[2], a_op[1], a_op[0]};
        rif.req_b = {b_op[3], b_op[2], b_op[1], b_op[0]};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

`ifdef FPA_ARB_SUB_EN
    localparam fp32_t EXP_SUB_B   = 32'hC124CCCC;
    localparam fp32_t EXP_SUB_SUM = 32'h03266665;
`else
    localparam fp32_t EXP_SUB_B   = 32'h4124CCCC;
    localparam fp32_t EXP_SUB_SUM = 32'h422ACCCC;
`endif

    initial begin
        // fairness + flush, single op, wrap, flush released during DRAIN
        vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 4'b0000, 32'h0,        1'b0};
        vecs[1]  = '{4'b1111, 1'b0, 4'b0010, 4'b0000, 32'h0,        1'b0};
        vecs[2]  = '{4'b1111, 1'b0, 4'b0100, 4'b0000, 32'h0,        1'b0};
        vecs[3]  = '{4'b1111, 1'b0, 4'b1000, 4'b0001, 32'h422ACCCC, 1'b0};
        vecs[4]  = '{4'b1111, 1'b0, 4'b0001, 4'b0010, 32'h40002001, 1'b0};
        vecs[5]  = '{4'b1111, 1'b0, 4'b0010, 4'b0100, 32'h40003002, 1'b0};
        vecs[6]  = '{4'b1111, 1'b0, 4'b0100, 4'b1000, 32'h40004003, 1'b0};
        vecs[7]  = '{4'b1111, 1'b0, 4'b1000, 4'b0001, 32'h422ACCCC, 1'b0};
        vecs[8]  = '{4'b1111, 1'b1, 4'b0000, 4'b0010, 32'h40002001, 1'b0};
        vecs[9]  = '{4'b1111, 1'b1, 4'b0000, 4'b0100, 32'h40003002, 1'b0};
        vecs[10] = '{4'b1111, 1'b1, 4'b0000, 4'b1000, 32'h40004003, 1'b0};
        vecs[11] = '{4'b1111, 1'b1, 4'b0000, 4'b0000, 32'h0,        1'b1};
        vecs[12] = '{4'b1111, 1'b0, 4'b0000, 4'b0000, 32'h0,        1'b1};
        vecs[13] = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 32'h0,        1'b0};
        vecs[14] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 32'h0,        1'b0};
        vecs[15] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 32'h0,        1'b0};
        vecs[16] = '{4'b0000, 1'b0, 4'b0000, 4'b0001, 32'h422ACCCC, 1'b0};
        vecs[17] = '{4'b1000, 1'b0, 4'b1000, 4'b0000, 32'h0,        1'b0};
        vecs[18] = '{4'b1001, 1'b0, 4'b0001, 4'b0000, 32'h0,        1'b0};
        vecs[19] = '{4'b1001, 1'b0, 4'b1000, 4'b0000, 32'h0,        1'b0};
        vecs[20] = '{4'b0000, 1'b0, 4'b0000, 4'b1000, 32'h40004003, 1'b0};
        vecs[21] = '{4'b0000, 1'b0, 4'b0000, 4'b0001, 32'h422ACCCC, 1'b0};
        vecs[22] = '{4'b0000, 1'b0, 4'b0000, 4'b1000, 32'h40004003, 1'b0};
        vecs[23] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 32'h0,        1'b0};
        vecs[24] = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 32'h0,        1'b0};
        vecs[25] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 32'h0,        1'b0};
        vecs[26] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 32'h0,        1'b0};
        vecs[27] = '{4'b0000, 1'b0, 4'b0000, 4'b0010, 32'h40002001, 1'b0};
        vecs[28] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 32'h0,        1'b1};
        vecs[29] = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 32'h0,        1'b0};
        vecs[30] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 32'h0,        1'b0};
        vecs[31] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 32'h0,        1'b0};
        vecs[32] = '{4'b0000, 1'b0, 4'b0000, 4'b0100, 32'h40003002, 1'b0};

        a_op[0] = 32'h42019999; b_op[0] = 32'h4124CCCC;
        a_op[1] = 32'h40000001; b_op[1] = 32'h00002000;
        a_op[2] = 32'h40000002; b_op[2] = 32'h00003000;
        a_op[3] = 32'h40000003; b_op[3] = 32'h00004000;
        drive_ops();
        rif.req_valid = '0;
        rif.req_op    = '0;
        flush         = 1'b0;
        reset         = 1'b1;
        #2 reset      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rif.req_valid = 4'b1111;
        @(negedge clk);
        check("reset ready",      32'(rif.req_ready), 32'h0);
        check("reset fpa_en",     32'(fpa_en),        32'h0);
        check("reset fpa_a",      fpa_a,              32'h0);
        check("reset fpa_b",      fpa_b,              32'h0);
        check("reset rsp_valid",  32'(rif.rsp_valid), 32'h0);
        check("reset flush_done", 32'(flush_done),    32'h0);
        next_cycle();
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            rif.req_valid = vecs[i].valid;
            flush         = vecs[i].flush;
            @(negedge clk);
            check($sformatf("v%0d ready", i),      32'(rif.req_ready), 32'(vecs[i].ready));
            check($sformatf("v%0d rsp_valid", i),  32'(rif.rsp_valid), 32'(vecs[i].rsp));
            check($sformatf("v%0d flush_done", i), 32'(flush_done),    32'(vecs[i].done));
            if (vecs[i].rsp != 4'b0000) begin
                check($sformatf("v%0d rsp_sum", i), rif.rsp_sum,          vecs[i].sum);
                check($sformatf("v%0d rsp_ovf", i), 32'(rif.rsp_overflow), 32'h0);
            end
            next_cycle();
        end

        // subtract on requester 2 (rr_ptr is 3 here)
        a_op[2] = 32'h42019999; b_op[2] = 32'h4124CCCC;
        drive_ops();
        rif.req_valid = 4'b0100;
        rif.req_op    = 4'b0100;
        @(negedge clk);
        check("sub ready", 32'(rif.req_ready), 32'h4);
        next_cycle();
        rif.req_valid = '0;
        rif.req_op    = '0;
        @(negedge clk);
        check("sub fpa_a", fpa_a, 32'h42019999);
        check("sub fpa_b", fpa_b, EXP_SUB_B);
        repeat (2) next_cycle();
        @(negedge clk);
        check("sub rsp_valid", 32'(rif.rsp_valid), 32'h4);
        check("sub rsp_sum",   rif.rsp_sum,        EXP_SUB_SUM);
        next_cycle();

        // infinity operand passes through untouched on requester 3
        a_op[3] = 32'h7F800000; b_op[3] = 32'hC1B428F5;
        drive_ops();
        rif.req_valid = 4'b1000;
        @(negedge clk);
        check("inf ready", 32'(rif.req_ready), 32'h8);
        next_cycle();
        rif.req_valid = '0;
        @(negedge clk);
        check("inf fpa_a", fpa_a, 32'h7F800000);
        check("inf fpa_b", fpa_b, 32'hC1B428F5);
        repeat (2) next_cycle();
        @(negedge clk);
        check("inf rsp_valid", 32'(rif.rsp_valid),    32'h8);
        check("inf rsp_sum",   rif.rsp_sum,           32'h413428F5);
        check("inf rsp_ovf",   32'(rif.rsp_overflow), 32'h1);
        next_cycle();

        // reset one cycle after a grant: the op must vanish
        rif.req_valid = 4'b0010;
        @(negedge clk);
        check("rst grant ready", 32'(rif.req_ready), 32'h2);
        next_cycle();
        rif.req_valid = 4'b1111;
        reset         = 1'b0;
        @(negedge clk);
        check("midrst ready",      32'(rif.req_ready), 32'h0);
        check("midrst fpa_en",     32'(fpa_en),        32'h0);
        check("midrst fpa_a",      fpa_a,              32'h0);
        check("midrst fpa_b",      fpa_b,              32'h0);
        check("midrst rsp_valid",  32'(rif.rsp_valid), 32'h0);
        check("midrst flush_done", 32'(flush_done),    32'h0);
        next_cycle();
        reset         = 1'b1;
        rif.req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("postrst%0d rsp_valid", c), 32'(rif.rsp_valid), 32'h0);
            check($sformatf("postrst%0d fpa_en", c),    32'(fpa_en),        32'h0);
            next_cycle();
        end
        rif.req_valid = 4'b1111;
        @(negedge clk);
        check("postrst ptr0 ready", 32'(rif.req_ready), 32'h1);
        next_cycle();
        rif.req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
